// File: rtl/sw_timer.sv
// Stopwatch time base: prescales the 1 ms strobe into hundredths and keeps
// elapsed time as five BCD digits (M:SS.hh) with a sticky wrap flag.
`timescale 1ns/1ps

module sw_timer #(
  parameter int MS_PER_TICK = 10,
  parameter int PRE_W       = 4
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       m_sec,
  input  logic       timer_on,
  input  logic       timer_clr,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] hund_tens,
  output logic [3:0] hund_ones,
  output logic       ovf
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_PER_TICK - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre;
  logic             accept;
  logic             tick;
  logic             c_ho, c_ht, c_so, c_st, c_mo;

  // Carry chain: each digit rolls only when every lower digit is at its top value.
  assign accept = timer_on & m_sec & ~timer_clr;
  assign tick   = accept & (pre == PRE_LAST);
  assign c_ho   = tick & (hund_ones == 4'd9);
  assign c_ht   = c_ho & (hund_tens == 4'd9);
  assign c_so   = c_ht & (sec_ones  == 4'd9);
  assign c_st   = c_so & (sec_tens  == 4'd5);
  assign c_mo   = c_st & (min_ones  == 4'd9);

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] top);
    return (d == top) ? 4'd0 : d + 4'd1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every digit samples
  // the pre-edge values of its neighbours, just like the combinational carries.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      pre       <= '0;
      hund_ones <= 4'd0;
      hund_tens <= 4'd0;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      ovf       <= 1'b0;
    end else if (timer_clr) begin
      pre       <= '0;
      hund_ones <= 4'd0;
      hund_tens <= 4'd0;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      ovf       <= 1'b0;
    end else if (accept) begin
      pre <= tick ? '0 : pre + PRE_ONE;
      if (tick) hund_ones <= bcd_inc(hund_ones, 4'd9);
      if (c_ho) hund_tens <= bcd_inc(hund_tens, 4'd9);
      if (c_ht) sec_ones  <= bcd_inc(sec_ones,  4'd9);
      if (c_so) sec_tens  <= bcd_inc(sec_tens,  4'd5);
      if (c_st) min_ones  <= bcd_inc(min_ones,  4'd9);
      if (c_mo) ovf       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_timer.sv
// Scoreboard bench for sw_timer: a slow instance (10 ms per hundredth) and a
// fast instance (1 ms per hundredth) checked against an arithmetic time model.
`timescale 1ns/1ps

module tb_sw_timer;

  typedef struct {
    int pre;
    int hund;   // total hundredths, 0..59999
    bit ovf;
  } model_t;

  typedef struct {
    string       tag;
    bit          fast;
    logic [20:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_btn;
  logic s_ms, s_on, s_clr;
  logic f_ms, f_on, f_clr;
  logic [3:0] s_mo, s_st, s_so, s_ht, s_ho;
  logic [3:0] f_mo, f_st, f_so, f_ht, f_ho;
  logic s_ovf, f_ovf;

  model_t m_slow, m_fast;
  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_err = 0;

  wire logic [20:0] slow_val = {s_ovf, s_mo, s_st, s_so, s_ht, s_ho};
  wire logic [20:0] fast_val = {f_ovf, f_mo, f_st, f_so, f_ht, f_ho};

  always #5 clk = ~clk;

  sw_timer u_slow (
    .clk(clk), .rst_btn(rst_btn), .m_sec(s_ms), .timer_on(s_on), .timer_clr(s_clr),
    .min_ones(s_mo), .sec_tens(s_st), .sec_ones(s_so), .hund_tens(s_ht),
    .hund_ones(s_ho), .ovf(s_ovf)
  );

  sw_timer #(.MS_PER_TICK(1), .PRE_W(4)) u_fast (
    .clk(clk), .rst_btn(rst_btn), .m_sec(f_ms), .timer_on(f_on), .timer_clr(f_clr),
    .min_ones(f_mo), .sec_tens(f_st), .sec_ones(f_so), .hund_tens(f_ht),
    .hund_ones(f_ho), .ovf(f_ovf)
  );

  function automatic model_t model_step(model_t m, int per, bit on, bit ms, bit clr);
    model_t n = m;
    if (clr) begin
      n.pre = 0; n.hund = 0; n.ovf = 1'b0;
    end else if (on && ms) begin
      if (m.pre == per - 1) begin
        n.pre  = 0;
        n.hund = m.hund + 1;
        if (n.hund == 60000) begin
          n.hund = 0;
          n.ovf  = 1'b1;
        end
      end else begin
        n.pre = m.pre + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [20:0] model_val(model_t m);
    int secs = (m.hund / 100) % 60;
    return {m.ovf, 4'(m.hund / 6000), 4'(secs / 10), 4'(secs % 10),
            4'((m.hund % 100) / 10), 4'(m.hund % 10)};
  endfunction

  function automatic void push_exp(string tag, bit fast);
    exp_t e;
    e.tag  = tag;
    e.fast = fast;
    e.val  = fast ? model_val(m_fast) : model_val(m_slow);
    sb.push_back(e);
  endfunction

  task automatic drive_slow(input bit on, input bit ms, input bit clr);
    @(negedge clk);
    s_on = on; s_ms = ms; s_clr = clr;
    m_slow = model_step(m_slow, 10, on, ms, clr);
  endtask

  task automatic drive_fast(input bit on, input bit ms, input bit clr);
    @(negedge clk);
    f_on = on; f_ms = ms; f_clr = clr;
    m_fast = model_step(m_fast, 1, on, ms, clr);
  endtask

  // Single-cycle strobes separated by an idle cycle.
  task automatic slow_strobes(input int n, input bit on);
    for (int i = 0; i < n; i++) begin
      drive_slow(on, 1'b1, 1'b0);
      drive_slow(on, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_btn = 1'b0;
    s_ms = 0; s_on = 0; s_clr = 0;
    f_ms = 0; f_on = 0; f_clr = 0;
    m_slow = '{0, 0, 1'b0};
    m_fast = '{0, 0, 1'b0};
    repeat (3) @(negedge clk);
    rst_btn = 1'b1;
    push_exp("reset_slow", 1'b0);
    push_exp("reset_fast", 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_cmp++;
      if ((e.fast ? fast_val : slow_val) !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.tag, e.fast ? fast_val : slow_val, e.val);
      end
    end
    // Reset in the middle of a count must clear before the next clock edge.
    slow_strobes(25, 1'b1);
    push_exp("pre_reset_count", 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
    @(negedge clk); #2;
    rst_btn = 1'b0;
    m_slow = '{0, 0, 1'b0};
    m_fast = '{0, 0, 1'b0};
    push_exp("async_reset", 1'b0);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
    repeat (3) @(negedge clk);
    rst_btn = 1'b1;
  endtask

  task automatic test_basic_count();
    int    steps[3] = '{10, 9, 1};
    string tags[3]  = '{"count_10", "count_19", "count_20"};
    exp_t  e;
    for (int k = 0; k < 3; k++) begin
      slow_strobes(steps[k], 1'b1);
      push_exp(tags[k], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (slow_val !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    slow_strobes(5, 1'b1);
    slow_strobes(50, 1'b0);
    push_exp("paused_50", 1'b0);
    slow_strobes(4, 1'b1);
    push_exp("resume_4", 1'b0);
    slow_strobes(1, 1'b1);
    push_exp("resume_5", 1'b0);
    // Expectations were queued in order; the DUT must still sit on the last one.
    @(posedge clk); #1;
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
  endtask

  task automatic test_pause_hold();
    exp_t e;
    slow_strobes(5, 1'b1);
    slow_strobes(50, 1'b0);
    push_exp("pause_hold", 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
    slow_strobes(4, 1'b1);
    push_exp("resume_4_hold", 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
    slow_strobes(1, 1'b1);
    push_exp("resume_5_step", 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
  endtask

  task automatic test_clear_collision();
    int    steps[3] = '{0, 9, 1};
    string tags[3]  = '{"clr_collide", "clr_plus_9", "clr_plus_10"};
    exp_t  e;
    // Continuous m_sec counts every cycle; land on 0:12.34 with prescaler mid-phase.
    while (m_slow.hund != 1234 || m_slow.pre != 3) drive_slow(1'b1, 1'b1, 1'b0);
    drive_slow(1'b1, 1'b0, 1'b0);
    push_exp("at_12_34", 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (slow_val !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
    end
    drive_slow(1'b1, 1'b1, 1'b1);
    drive_slow(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      slow_strobes(steps[k], 1'b1);
      push_exp(tags[k], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (slow_val !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.tag, slow_val, e.val);
      end
    end
  endtask

  // Fast instance: one hundredth per cycle, walked to fixed checkpoints.
  task automatic test_carries_and_wrap();
    int    targets[6] = '{5999, 6000, 59999, 60000, 60100, -1};
    string tags[6]    = '{"at_0_59_99", "carry_1_00_00", "at_9_59_99",
                          "wrap_ovf", "ovf_sticky", "clr_ovf"};
    int    done = 0;
    exp_t  e;
    drive_fast(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (targets[k] < 0) begin
        drive_fast(1'b1, 1'b0, 1'b1);
      end else begin
        while (done < targets[k]) begin
          drive_fast(1'b1, 1'b1, 1'b0);
          done++;
        end
      end
      drive_fast(1'b0, 1'b0, 1'b0);
      push_exp(tags[k], 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (fast_val !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.tag, fast_val, e.val);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_count();
    test_pause_hold();
    test_pause();
    test_clear_collision();
    test_carries_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_timer.md
Name: sw_timer

Overview:
- Stopwatch time-base counter directly downstream of the stopwatch control FSM.
- Consumes timer_on and timer_clr from the control FSM, plus the shared 1 ms strobe m_sec.
- Accumulates elapsed time as 5 BCD digits in M:SS.hh format for the display driver.
- Flags a wrap past 9:59.99 with a sticky overflow bit.

Parameters:
- MS_PER_TICK, 10: number of m_sec strobes per hundredth-of-second increment; legal range 1..15.
- PRE_W, 4: prescaler width; must satisfy 2^PRE_W >= MS_PER_TICK.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_btn  input  1  asynchronous, active-low reset.
- m_sec  input  1  1 ms strobe, one clk cycle wide.
- timer_on  input  1  counting enable from the control FSM.
- timer_clr  input  1  synchronous clear request from the control FSM.
- min_ones  output  4  BCD minutes digit, 0-9.
- sec_tens  output  4  BCD tens-of-seconds digit, 0-5.
- sec_ones  output  4  BCD seconds digit, 0-9.
- hund_tens  output  4  BCD tenths digit, 0-9.
- hund_ones  output  4  BCD hundredths digit, 0-9.
- ovf  output  1  sticky flag: time wrapped past 9:59.99.

Behaviour:
- Reset: rst_btn low asynchronously forces all digits to 0, the prescaler to 0 and ovf to 0. Reset is held while rst_btn is low. Release is synchronous to the next clk edge.
- All outputs are registered directly; there is no combinational path from inputs to outputs.
- Priority per clk edge: timer_clr, then count, then hold.
- Clear: timer_clr=1 on a clk edge zeroes all digits, the prescaler and ovf.
  - Clear takes effect regardless of timer_on and m_sec.
  - A coincident m_sec strobe is discarded.
- Count enable: a strobe is accepted only when timer_on=1, m_sec=1 and timer_clr=0 on the same edge.
- Prescaler:
  - On an accepted strobe, if the prescaler equals MS_PER_TICK-1, it returns to 0 and a hundredth-step is issued in the same edge.
  - Otherwise the prescaler increments by 1.
- Hundredth-step: BCD ripple on the same edge.
  - hund_ones 9->0 carries into hund_tens.
  - hund_tens 9->0 carries into sec_ones.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 is a full wrap.
  - A digit without an incoming carry holds its value.
- Full wrap: 9:59.99 steps to 0:00.00 and ovf is set to 1. ovf stays at 1 until timer_clr or reset; further wraps leave it at 1.
- Latency: new digit values are visible immediately after the clk edge that accepts the final strobe of a hundredth.
- Pause: timer_on=0 freezes the digits and the prescaler at their current values. The prescaler is not reset, so a resumed count keeps sub-hundredth phase.
- m_sec high for more than one cycle counts once per cycle high. Single-cycle width is the upstream contract.
- Digits never take non-BCD values. Out-of-range digit states are unreachable and need not be handled.
- Implementation: a single always block with an asynchronous negedge rst_btn; the carry chain is computed combinationally within that edge.

Test Plan:
- Reset: hold rst_btn=0 for 3 cycles mid-count (digits nonzero) -> all digits 0 and ovf=0 asynchronously, before the next clk edge.
- Basic count (MS_PER_TICK=10): timer_on=1, apply 10 m_sec strobes -> hund_ones=1, all other digits 0. Apply 9 more strobes -> still 0:00.01. The 20th strobe -> 0:00.02.
- Pause: during counting, drop timer_on after 5 strobes of a hundredth and issue 50 strobes -> digits unchanged. Raise timer_on and apply 5 strobes -> the hundredth increments on the 5th.
- Carries (MS_PER_TICK=1): 5999 strobes -> 0:59.99. The next strobe -> 1:00.00 with ovf=0.
- Full wrap (MS_PER_TICK=1): 59999 strobes -> 9:59.99. The next strobe -> 0:00.00 and ovf=1. 100 more strobes -> 0:01.00 with ovf still 1.
- Clear collision: at 0:12.34, assert timer_clr with timer_on=1 and m_sec=1 on the same edge -> 0:00.00, ovf=0, prescaler 0. The strobe is not counted: after 10 further strobes the display reads 0:00.01.
